// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the six-motor step/direction controller.
package motor_ctrl_pkg;

  localparam int NUM_MOTORS = 6;
  localparam int POS_W      = 10;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CALC,
    S_CHECK,
    S_STEP_HI,
    S_STEP_LO,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } motor_sel_t;

  // x*100 = x<<6 + x<<5 + x<<2, x*10 = x<<3 + x<<1
  function automatic logic [POS_W-1:0] bcd3_to_bin(input logic [3:0] d_hund,
                                                   input logic [3:0] d_tens,
                                                   input logic [3:0] d_ones);
    logic [POS_W-1:0] h, t, o;
    h = POS_W'(d_hund);
    t = POS_W'(d_tens);
    o = POS_W'(d_ones);
    return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + o;
  endfunction

  function automatic motor_sel_t onehot6_to_idx(input logic [NUM_MOTORS-1:0] sel);
    motor_sel_t  res;
    int unsigned n_set;
    res   = '0;
    n_set = 0;
    for (int k = 0; k < NUM_MOTORS; k++) begin
      if (sel[k]) begin
        res.idx = IDX_W'(k);
        n_set++;
      end
    end
    res.valid = (n_set == 1);
    return res;
  endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Single step pulse timer: high for STEP_HIGH cycles, whole period STEP_PERIOD cycles.
module step_pulse_gen #(
  parameter int STEP_PERIOD = 50000,
  parameter int STEP_HIGH   = 100
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_pulse,
  output logic o_pulse_end,
  output logic o_period_end
);

  localparam int CW = $clog2(STEP_PERIOD);
  localparam logic [CW-1:0] C_HI_LAST  = CW'(STEP_HIGH - 1);
  localparam logic [CW-1:0] C_PER_LAST = CW'(STEP_PERIOD - 1);

  logic          r_active;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  assign o_pulse      = r_pulse;
  assign o_pulse_end  = r_pulse && (r_cnt == C_HI_LAST);
  assign o_period_end = r_active && (r_cnt == C_PER_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_pulse  <= 1'b1;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (o_pulse_end)
        r_pulse <= 1'b0;
      if (o_period_end) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motor_step_ctrl.sv
// Converts a latched BCD target into step/direction pulses for one of six motors,
// tracking every motor's absolute position.
module motor_step_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int STEP_PERIOD = 50000,
  parameter int STEP_HIGH   = 100
) (
  input  logic                  sysclk,
  input  logic                  INIT_n,
  input  logic                  Enter,
  input  logic [3:0]            TValue0,
  input  logic [3:0]            TValue1,
  input  logic [3:0]            TValue2,
  input  logic [NUM_MOTORS-1:0] Motor,
  output logic [NUM_MOTORS-1:0] Step,
  output logic [NUM_MOTORS-1:0] Dir,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [POS_W-1:0]      CurPos
);

  state_t                r_state;
  logic                  r_enter_q;
  logic [3:0]            r_d0, r_d1, r_d2;
  logic [NUM_MOTORS-1:0] r_motor;
  logic [POS_W-1:0]      r_target;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_have_cmd;
  logic [POS_W-1:0]      r_pos [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] r_dir;
  logic                  r_busy, r_done, r_err;

  motor_sel_t            w_sel;
  logic                  w_digits_ok;
  logic [POS_W-1:0]      w_target;
  logic [POS_W-1:0]      w_sel_pos;
  logic                  w_start;
  logic                  w_pulse, w_pulse_end, w_period_end;

  assign w_sel       = onehot6_to_idx(r_motor);
  assign w_digits_ok = (r_d0 <= 4'd9) && (r_d1 <= 4'd9) && (r_d2 <= 4'd9);
  assign w_target    = bcd3_to_bin(r_d0, r_d1, r_d2);
  assign w_sel_pos   = r_pos[w_sel.idx];
  assign w_start     = (r_state == S_CHECK) && (r_pos[r_idx] != r_target);

  step_pulse_gen #(
    .STEP_PERIOD(STEP_PERIOD),
    .STEP_HIGH  (STEP_HIGH)
  ) u_pulse (
    .i_clk       (sysclk),
    .i_rst_n     (INIT_n),
    .i_start     (w_start),
    .o_pulse     (w_pulse),
    .o_pulse_end (w_pulse_end),
    .o_period_end(w_period_end)
  );

  assign Step   = w_pulse ? (NUM_MOTORS'(1) << r_idx) : '0;
  assign Dir    = r_dir;
  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Err    = r_err;
  assign CurPos = r_have_cmd ? r_pos[r_idx] : '0;

  // Dir is also preset in CALC so it is stable a cycle ahead of the first step
  always_ff @(posedge sysclk or negedge INIT_n) begin
    if (!INIT_n) begin
      r_state    <= S_IDLE;
      r_enter_q  <= 1'b0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_motor    <= '0;
      r_target   <= '0;
      r_idx      <= '0;
      r_have_cmd <= 1'b0;
      r_dir      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int k = 0; k < NUM_MOTORS; k++)
        r_pos[k] <= '0;
    end else begin
      r_enter_q <= Enter;
      case (r_state)
        S_IDLE: begin
          if (Enter && !r_enter_q) begin
            r_busy  <= 1'b1;
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          r_d0    <= TValue0;
          r_d1    <= TValue1;
          r_d2    <= TValue2;
          r_motor <= Motor;
          r_state <= S_CALC;
        end
        S_CALC: begin
          if (!w_digits_ok || !w_sel.valid) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_target   <= w_target;
            r_idx      <= w_sel.idx;
            r_have_cmd <= 1'b1;
            if (w_target != w_sel_pos)
              r_dir[w_sel.idx] <= (w_target > w_sel_pos);
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_pos[r_idx] == r_target) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_dir[r_idx] <= (r_target > r_pos[r_idx]);
            r_state      <= S_STEP_HI;
          end
        end
        S_STEP_HI: begin
          if (w_pulse_end) begin
            r_pos[r_idx] <= r_dir[r_idx] ? r_pos[r_idx] + 1'b1 : r_pos[r_idx] - 1'b1;
            r_state      <= S_STEP_LO;
          end
        end
        S_STEP_LO: begin
          if (w_period_end)
            r_state <= S_CHECK;
        end
        S_DONE, S_ERR: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_step_ctrl.sv
// Directed bench for motor_step_ctrl with STEP_PERIOD=8, STEP_HIGH=2.
module tb_motor_step_ctrl;
  import motor_ctrl_pkg::*;

  logic                  sysclk = 1'b0;
  logic                  INIT_n;
  logic                  Enter;
  logic [3:0]            TValue0, TValue1, TValue2;
  logic [NUM_MOTORS-1:0] Motor;
  logic [NUM_MOTORS-1:0] Step, Dir;
  logic                  Busy, Done, Err;
  logic [POS_W-1:0]      CurPos;

  int total = 0;
  int bad   = 0;

  // results gathered by applyStimulus for one command
  int               doneAt, errAt, firstRise, badRuns, dirWrong;
  int               rises [NUM_MOTORS];
  logic             busyN1, busyAtEnd, busyAfter, pulseAfter, stepAtAbort;
  logic [NUM_MOTORS-1:0] dirBeforeFirst;

  motor_step_ctrl #(.STEP_PERIOD(8), .STEP_HIGH(2)) dut (
    .sysclk (sysclk),
    .INIT_n (INIT_n),
    .Enter  (Enter),
    .TValue0(TValue0),
    .TValue1(TValue1),
    .TValue2(TValue2),
    .Motor  (Motor),
    .Step   (Step),
    .Dir    (Dir),
    .Busy   (Busy),
    .Done   (Done),
    .Err    (Err),
    .CurPos (CurPos)
  );

  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Issue one command (Enter held high) and watch cycles n+1.. until one cycle after Done/Err
  task automatic applyStimulus(input logic [5:0] m, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic expDir, input int budget,
                               input int toggleAt, input int abortAt);
    int cyc, endAt;
    int run [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] prevStep, prevDir;
    @(negedge sysclk);
    Motor = m; TValue0 = a; TValue1 = b; TValue2 = c; Enter = 1'b1;
    @(posedge sysclk);
    doneAt = -1; errAt = -1; firstRise = -1; badRuns = 0; dirWrong = 0; endAt = -1;
    busyN1 = 1'b0; busyAtEnd = 1'b0; busyAfter = 1'b1; pulseAfter = 1'b1; stepAtAbort = 1'b0;
    dirBeforeFirst = '0;
    for (int k = 0; k < NUM_MOTORS; k++) begin rises[k] = 0; run[k] = 0; end
    prevStep = Step; prevDir = Dir;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge sysclk);
      if (cyc == abortAt) begin
        stepAtAbort = Step[5];
        INIT_n = 1'b0;
        #1;
        return;
      end
      if (toggleAt > 0 && cyc == toggleAt) Enter = 1'b0;
      if (toggleAt > 0 && cyc == toggleAt + 1) Enter = 1'b1;
      if (cyc == 1) busyN1 = Busy;
      for (int k = 0; k < NUM_MOTORS; k++) begin
        if (Step[k] && !prevStep[k]) begin
          rises[k]++;
          if (firstRise < 0) begin
            firstRise = cyc;
            dirBeforeFirst = prevDir;
          end
        end
        if (Step[k]) begin
          run[k]++;
          if (Dir[k] !== expDir) dirWrong++;
        end else if (prevStep[k]) begin
          if (run[k] != 2) badRuns++;
          run[k] = 0;
        end
      end
      prevStep = Step; prevDir = Dir;
      if (Done && doneAt < 0) doneAt = cyc;
      if (Err && errAt < 0) errAt = cyc;
      if (endAt < 0 && (doneAt >= 0 || errAt >= 0)) begin
        endAt = cyc + 1;
        busyAtEnd = Busy;
      end else if (cyc == endAt) begin
        busyAfter  = Busy;
        pulseAfter = Done | Err;
        break;
      end
    end
    Enter = 1'b0;
    @(negedge sysclk);
  endtask

  initial begin
    INIT_n = 1'b0; Enter = 1'b0; Motor = '0;
    TValue0 = '0; TValue1 = '0; TValue2 = '0;
    repeat (3) @(negedge sysclk);
    checkOutput("rst_step", Step, 0);
    checkOutput("rst_dir", Dir, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done_err", {Done, Err}, 0);
    checkOutput("rst_curpos", CurPos, 0);
    INIT_n = 1'b1;
    repeat (2) @(negedge sysclk);

    $display("[TB] motor 1 up to 3");
    applyStimulus(6'b000001, 4'd0, 4'd0, 4'd3, 1'b1, 100, 0, 0);
    checkOutput("t1_done_at", doneAt, 31);
    checkOutput("t1_first_rise", firstRise, 4);
    checkOutput("t1_rises_m1", rises[0], 3);
    checkOutput("t1_rises_other", rises[1] + rises[2] + rises[3] + rises[4] + rises[5], 0);
    checkOutput("t1_high_len", badRuns, 0);
    checkOutput("t1_dir_during_step", dirWrong, 0);
    checkOutput("t1_dir_before_step", dirBeforeFirst[0], 1);
    checkOutput("t1_busy_n1", busyN1, 1);
    checkOutput("t1_busy_after", busyAfter, 0);
    checkOutput("t1_single_pulse", pulseAfter, 0);
    checkOutput("t1_curpos", CurPos, 3);
    checkOutput("t1_dir", Dir, 6'b000001);

    $display("[TB] motor 1 down to 1");
    applyStimulus(6'b000001, 4'd0, 4'd0, 4'd1, 1'b0, 100, 0, 0);
    checkOutput("t2_done_at", doneAt, 22);
    checkOutput("t2_rises_m1", rises[0], 2);
    checkOutput("t2_high_len", badRuns, 0);
    checkOutput("t2_dir_during_step", dirWrong, 0);
    checkOutput("t2_dir_before_step", dirBeforeFirst[0], 0);
    checkOutput("t2_curpos", CurPos, 1);

    $display("[TB] repeat target, no motion");
    applyStimulus(6'b000001, 4'd0, 4'd0, 4'd1, 1'b0, 100, 0, 0);
    checkOutput("t3_done_at", doneAt, 4);
    checkOutput("t3_rises", rises[0] + rises[5], 0);
    checkOutput("t3_busy_n1", busyN1, 1);
    checkOutput("t3_busy_at_done", busyAtEnd, 1);
    checkOutput("t3_busy_after", busyAfter, 0);
    checkOutput("t3_dir", Dir, 0);

    $display("[TB] rejected commands");
    applyStimulus(6'b000000, 4'd0, 4'd0, 4'd5, 1'b0, 100, 0, 0);
    checkOutput("t4a_err_at", errAt, 3);
    checkOutput("t4a_no_done", doneAt, -1);
    checkOutput("t4a_busy_after", busyAfter, 0);
    applyStimulus(6'b000011, 4'd0, 4'd0, 4'd5, 1'b0, 100, 0, 0);
    checkOutput("t4b_err_at", errAt, 3);
    checkOutput("t4b_rises", rises[0] + rises[1], 0);
    applyStimulus(6'b000001, 4'hA, 4'd0, 4'd0, 1'b0, 100, 0, 0);
    checkOutput("t4c_err_at", errAt, 3);
    checkOutput("t4c_rises", rises[0], 0);
    checkOutput("t4c_single_pulse", pulseAfter, 0);
    checkOutput("t4_curpos", CurPos, 1);

    $display("[TB] motor 6 up to 999 with Enter toggled mid-move");
    applyStimulus(6'b100000, 4'd9, 4'd9, 4'd9, 1'b1, 9100, 50, 0);
    checkOutput("t5_done_at", doneAt, 4 + 999 * 9);
    checkOutput("t5_rises_m6", rises[5], 999);
    checkOutput("t5_rises_m1", rises[0], 0);
    checkOutput("t5_high_len", badRuns, 0);
    checkOutput("t5_dir_during_step", dirWrong, 0);
    checkOutput("t5_curpos", CurPos, 999);
    repeat (3) @(negedge sysclk);
    checkOutput("t5_no_queued_cmd", Busy, 0);
    applyStimulus(6'b000001, 4'd0, 4'd0, 4'd1, 1'b0, 100, 0, 0);
    checkOutput("t5_m1_done_at", doneAt, 4);
    checkOutput("t5_m1_curpos", CurPos, 1);

    $display("[TB] abort during motion");
    applyStimulus(6'b100000, 4'd5, 4'd0, 4'd0, 1'b0, 200, 0, 94);
    Enter = 1'b0;
    checkOutput("t6_step_before_abort", stepAtAbort, 1);
    checkOutput("t6_step", Step, 0);
    checkOutput("t6_busy", Busy, 0);
    checkOutput("t6_curpos", CurPos, 0);
    @(negedge sysclk);
    INIT_n = 1'b1;
    repeat (2) @(negedge sysclk);
    applyStimulus(6'b100000, 4'd0, 4'd0, 4'd2, 1'b1, 100, 0, 0);
    checkOutput("t6_done_at", doneAt, 22);
    checkOutput("t6_rises_m6", rises[5], 2);
    checkOutput("t6_dir_during_step", dirWrong, 0);
    checkOutput("t6_curpos", CurPos, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
